// File: rtl/sw_frqw_pkg.sv
// Shared types and constants for the switch debouncer / DDS tuning-word block.
package sw_frqw_pkg;

    localparam int FRQ_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // A 1-cycle qualification window still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous bus; async active-low reset.
module sync_2ff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sw_frqw_debounce.sv
// Switch debouncer producing a stable switch word and a 6-bit DDS tuning word.
// Optional macro FRQW_ZERO_CLAMP_EN forces frq_w to 1 when the low six bits are zero.
module sw_frqw_debounce
    import sw_frqw_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 100000,
    parameter int SW_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SW_W-1:0]  sw_in,
    output logic [SW_W-1:0]  sw_stable,
    output logic [FRQ_W-1:0] frq_w,
    output logic             upd,
    output logic             busy
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [SW_W-1:0]  sw_sync;
    logic [SW_W-1:0]  cand_q, cand_d;
    logic [SW_W-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;

    sync_2ff #(.W(SW_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sw_in),
        .q_o   (sw_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // The stable word is loaded on the edge that enters COMMIT, so it changes
    // in exactly the cycle upd (state == COMMIT) is high.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        case (state_q)
            IDLE: begin
                if (sw_sync != stable_q) begin
                    cand_d  = sw_sync;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sw_sync == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = cand_q;
                        state_d  = COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sw_sync == stable_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cand_d = sw_sync;
                    cnt_d  = '0;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign sw_stable = stable_q;
    assign upd       = (state_q == COMMIT);
    assign busy      = (state_q != IDLE);

`ifdef FRQW_ZERO_CLAMP_EN
    // A zero tuning word would stall the DDS phase accumulator.
    assign frq_w = (stable_q[FRQ_W-1:0] == '0) ? FRQ_W'(1) : stable_q[FRQ_W-1:0];
`else
    assign frq_w = stable_q[FRQ_W-1:0];
`endif

endmodule

// File: tb/tb_sw_frqw_debounce.sv
// Randomized and directed bench for sw_frqw_debounce with DEBOUNCE_CNT=4.
module tb_sw_frqw_debounce;

    localparam int D    = 4;
    localparam int SW_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SW_W-1:0] sw_in = '0;
    logic [SW_W-1:0] sw_stable;
    logic [5:0]      frq_w;
    logic            upd;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // Reference model: a new value is accepted once D+1 consecutive eligible
    // synchronized samples agree on a value different from the stable word.
    // The sample seen during the commit cycle itself is not eligible.
    logic [SW_W-1:0] m_x1, m_y, m_s, m_last;
    int              m_cyc = 0;
    int              m_run, m_elig;
    logic            exp_upd, exp_busy;

    sw_frqw_debounce #(.DEBOUNCE_CNT(D), .SW_W(SW_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_in     (sw_in),
        .sw_stable (sw_stable),
        .frq_w     (frq_w),
        .upd       (upd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] frq_of(input logic [SW_W-1:0] s);
`ifdef FRQW_ZERO_CLAMP_EN
        return (s[5:0] == 6'd0) ? 6'd1 : s[5:0];
`else
        return s[5:0];
`endif
    endfunction

    task automatic model_reset();
        m_x1 = '0; m_y = '0; m_s = '0; m_last = '0;
        m_run = 0; m_elig = m_cyc;
        exp_upd = 1'b0; exp_busy = 1'b0;
    endtask

    task automatic step(input logic [SW_W-1:0] v);
        logic [SW_W-1:0] yp;
        sw_in = v;
        @(posedge clk);
        m_cyc++;
        yp   = m_y;
        m_y  = m_x1;
        m_x1 = v;
        exp_upd = 1'b0;
        if (m_cyc - 1 < m_elig) m_run = 0;
        else if (m_run > 0 && yp == m_last) m_run++;
        else begin
            m_run  = 1;
            m_last = yp;
        end
        exp_busy = (m_cyc - 1 >= m_elig) && (yp != m_s);
        if (m_run >= D + 1 && m_last != m_s) begin
            exp_upd  = 1'b1;
            exp_busy = 1'b1;
            m_s      = m_last;
            m_run    = 0;
            m_elig   = m_cyc + 1;
        end
        #1;
    endtask

    task automatic rst_assert();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic rst_release(input logic [SW_W-1:0] v);
        sw_in = v;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_assert();
        checks += 4;
        if (upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b want 0", upd); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (sw_stable !== 8'h00) begin errors++; $display("FAIL reset_stable: got %h want 00", sw_stable); end
        if (frq_w !== frq_of(8'h00)) begin errors++; $display("FAIL reset_frq: got %h want %h", frq_w, frq_of(8'h00)); end
        rst_release(8'h00);
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 10; i++) begin
            step(8'h00);
            checks += 3;
            if (upd !== 1'b0) begin errors++; $display("FAIL idle_upd: cyc %0d got %b want 0", i, upd); end
            if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: cyc %0d got %b want 0", i, busy); end
            if (sw_stable !== 8'h00) begin errors++; $display("FAIL idle_stable: cyc %0d got %h want 00", i, sw_stable); end
        end
    endtask

    task automatic test_clean_step();
        int lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step(8'h15);
            if (upd === 1'b1) lat = i;
        end
        checks += 3;
        if (lat != D + 3) begin errors++; $display("FAIL clean_latency: got %0d want %0d", lat, D + 3); end
        if (sw_stable !== 8'h15) begin errors++; $display("FAIL clean_stable: got %h want 15", sw_stable); end
        if (frq_w !== 6'h15) begin errors++; $display("FAIL clean_frq: got %h want 15", frq_w); end
        step(8'h15);
        checks += 2;
        if (upd !== 1'b0) begin errors++; $display("FAIL clean_single_pulse: got %b want 0", upd); end
        if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        bit saw_busy = 1'b0;
        rst_assert();
        rst_release(8'h00);
        for (int i = 0; i < 14; i++) begin
            step((i < 2) ? 8'h15 : 8'h00);
            if (upd === 1'b1) pulses++;
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        checks += 4;
        if (pulses != 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", pulses); end
        if (saw_busy !== 1'b1) begin errors++; $display("FAIL bounce_busy_seen: got %b want 1", saw_busy); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bounce_busy_end: got %b want 0", busy); end
        if (sw_stable !== 8'h00) begin errors++; $display("FAIL bounce_stable: got %h want 00", sw_stable); end
    endtask

    task automatic test_recapture();
        int pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step((i < 3) ? 8'h03 : 8'h07);
            if (upd === 1'b1) pulses++;
        end
        checks += 3;
        if (pulses != 1) begin errors++; $display("FAIL recap_pulses: got %0d want 1", pulses); end
        if (sw_stable !== 8'h07) begin errors++; $display("FAIL recap_stable: got %h want 07", sw_stable); end
        if (frq_w !== 6'h07) begin errors++; $display("FAIL recap_frq: got %h want 07", frq_w); end
    endtask

    task automatic test_high_bits();
        int pulses = 0;
        logic [5:0] want40;
`ifdef FRQW_ZERO_CLAMP_EN
        want40 = 6'd1;
`else
        want40 = 6'd0;
`endif
        repeat (10) step(8'h15);
        for (int i = 0; i < 10; i++) begin
            step(8'h40);
            if (upd === 1'b1) pulses++;
        end
        checks += 3;
        if (pulses != 1) begin errors++; $display("FAIL hi40_pulses: got %0d want 1", pulses); end
        if (sw_stable !== 8'h40) begin errors++; $display("FAIL hi40_stable: got %h want 40", sw_stable); end
        if (frq_w !== want40) begin errors++; $display("FAIL hi40_frq: got %h want %h", frq_w, want40); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(8'hC0);
            if (upd === 1'b1) pulses++;
        end
        checks += 3;
        if (pulses != 1) begin errors++; $display("FAIL hiC0_pulses: got %0d want 1", pulses); end
        if (sw_stable !== 8'hC0) begin errors++; $display("FAIL hiC0_stable: got %h want c0", sw_stable); end
        if (frq_w !== want40) begin errors++; $display("FAIL hiC0_frq: got %h want %h", frq_w, want40); end
    endtask

    task automatic test_reset_mid_settle();
        int lat = -1;
        rst_assert();
        rst_release(8'h00);
        repeat (4) step(8'h2A);
        checks += 1;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        rst_assert();
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        if (upd !== 1'b0) begin errors++; $display("FAIL mid_rst_upd: got %b want 0", upd); end
        if (sw_stable !== 8'h00) begin errors++; $display("FAIL mid_rst_stable: got %h want 00", sw_stable); end
        if (frq_w !== frq_of(8'h00)) begin errors++; $display("FAIL mid_rst_frq: got %h want %h", frq_w, frq_of(8'h00)); end
        rst_release(8'h2A);
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            step(8'h2A);
            if (upd === 1'b1) lat = i;
        end
        checks += 2;
        if (lat != D + 3) begin errors++; $display("FAIL mid_latency: got %0d want %0d", lat, D + 3); end
        if (sw_stable !== 8'h2A) begin errors++; $display("FAIL mid_stable: got %h want 2a", sw_stable); end
    endtask

    task automatic test_random();
        logic [SW_W-1:0] pool [6] = '{8'h00, 8'h15, 8'h2A, 8'h40, 8'h07, 8'hC0};
        logic [SW_W-1:0] v;
        int len;
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(39, 0) == 0) begin
                rst_assert();
                rst_release(pool[$urandom_range(5, 0)]);
            end
            v   = ($urandom_range(4, 0) == 0) ? SW_W'($urandom) : pool[$urandom_range(5, 0)];
            len = $urandom_range(8, 1);
            for (int k = 0; k < len; k++) begin
                step(v);
                checks += 4;
                if (upd !== exp_upd) begin errors++; $display("FAIL rand_upd: cyc %0d got %b want %b", m_cyc, upd, exp_upd); end
                if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy: cyc %0d got %b want %b", m_cyc, busy, exp_busy); end
                if (sw_stable !== m_s) begin errors++; $display("FAIL rand_stable: cyc %0d got %h want %h", m_cyc, sw_stable, m_s); end
                if (frq_w !== frq_of(m_s)) begin errors++; $display("FAIL rand_frq: cyc %0d got %h want %h", m_cyc, frq_w, frq_of(m_s)); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_idle_hold();
        test_clean_step();
        test_bounce();
        test_recapture();
        test_high_bits();
        test_reset_mid_settle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_frqw_debounce.md
SW_FRQW_DEBOUNCE -- requirements
Module: sw_frqw_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 100000, meaning the stable-cycle count required before accepting a switch change (1 ms at a 10 ns clock).
REQ-002 SHALL have parameter SW_W, default 8, meaning the switch bus width.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sw_in  input  SW_W  raw, asynchronous switch levels.
REQ-006 SHALL have port sw_stable  output  SW_W  debounced switch word, consumed by the BCD converter.
REQ-007 SHALL have port frq_w  output  6  DDS frequency tuning word, derived from sw_stable[5:0].
REQ-008 SHALL have port upd  output  1  one-cycle pulse when sw_stable/frq_w take a new value.
REQ-009 SHALL have port busy  output  1  high while a candidate change is being qualified.

Function
REQ-010 SHALL pass sw_in through a two-flop synchronizer; only the synchronized value (sw_sync) is used downstream.
REQ-011 SHALL implement FSM states IDLE, SETTLE, COMMIT.
REQ-012 In IDLE, when sw_sync != sw_stable, SHALL capture sw_sync as candidate, clear the counter and go to SETTLE.
REQ-013 In SETTLE, when sw_sync == candidate, SHALL increment the counter; on reaching DEBOUNCE_CNT-1 SHALL go to COMMIT.
REQ-014 In SETTLE, when sw_sync != candidate and != sw_stable, SHALL recapture candidate, clear the counter and stay in SETTLE.
REQ-015 In SETTLE, when sw_sync returns to sw_stable, SHALL go to IDLE with no update and no upd pulse.
REQ-016 In COMMIT, SHALL load sw_stable <= candidate, assert upd for exactly that one cycle, and return to IDLE.
REQ-017 SHALL update sw_stable and frq_w in the same cycle that upd is high, never otherwise.
REQ-018 End-to-end latency from a clean sw_in step to upd high SHALL be DEBOUNCE_CNT+3 clock cycles.
REQ-019 busy SHALL be high in SETTLE and COMMIT, low in IDLE.
REQ-020 Counter SHALL be sized $clog2(DEBOUNCE_CNT) bits minimum and SHALL never wrap; DEBOUNCE_CNT=1 SHALL commit after a single stable SETTLE cycle.
REQ-021 A change of only bits above [5:0] SHALL still update sw_stable and pulse upd; frq_w stays numerically unchanged.

Reset
REQ-022 Asserting rst_n low SHALL immediately force state IDLE, counter 0, candidate 0, synchronizer flops 0, sw_stable 0, upd 0, busy 0, frq_w to its reset value (REQ-024/025).
REQ-023 Reset asserted mid-SETTLE SHALL discard the candidate; after release the block requalifies sw_in from scratch.

Configuration
REQ-024 With macro FRQW_ZERO_CLAMP_EN defined, frq_w SHALL equal 6'd1 whenever sw_stable[5:0] == 0 (including reset), preventing a stalled DDS.
REQ-025 Without FRQW_ZERO_CLAMP_EN, frq_w SHALL equal sw_stable[5:0] exactly, reset value 0.

Structure
REQ-026 Shared package sw_frqw_pkg SHALL hold the FSM state enum and the FRQ_W width constant (6).
REQ-027 Synchronizer SHALL be a separate sub-module sync_2ff (parameterized width, async active-low reset).

Verification (DEBOUNCE_CNT=4 in sim)
REQ-028 Reset, then sw_in=8'h00 held -> sw_stable=0, upd never pulses, busy=0.
REQ-029 sw_in 00->8'h15 clean step -> upd single pulse 7 cycles later, sw_stable=8'h15, frq_w=6'h15.
REQ-030 sw_in 00->8'h15, bounce back to 00 after 2 cycles -> no upd, busy falls, sw_stable stays 0.
REQ-031 sw_in 00->8'h03 then 8'h07 mid-SETTLE -> counter restarts, single upd, sw_stable=8'h07.
REQ-032 sw_in 8'h15->8'h40 -> with FRQW_ZERO_CLAMP_EN frq_w=1, without frq_w=0; upd pulses in both builds.
REQ-033 rst_n low during SETTLE of 8'h2A -> all outputs reset; after release with 8'h2A held, upd fires 7 cycles later.
